// File: rtl/tl_log_collector.sv
// tl_log_collector: passive TileLink A-E beat monitor; timestamps fired beats into per-channel FIFOs and emits one record per cycle round-robin
// ports: clock/reset (sync, active-high), log_en; a..e channel handshakes and fields (observed only);
//        record outputs channel/opcode/param/source/sink/address/data_0..3/stamp with wen strobe; overflow (sticky), drop_cnt (saturating)
module tl_log_collector #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W = 48,
  parameter int SOURCE_W = 7,
  parameter int SINK_W = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                log_en,
  input  logic                a_valid,
  input  logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_param,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [255:0]        a_data,
  input  logic                b_valid,
  input  logic                b_ready,
  input  logic [2:0]          b_opcode,
  input  logic [1:0]          b_param,
  input  logic [SOURCE_W-1:0] b_source,
  input  logic [ADDR_W-1:0]   b_address,
  input  logic                c_valid,
  input  logic                c_ready,
  input  logic [2:0]          c_opcode,
  input  logic [2:0]          c_param,
  input  logic [SOURCE_W-1:0] c_source,
  input  logic [ADDR_W-1:0]   c_address,
  input  logic [255:0]        c_data,
  input  logic                d_valid,
  input  logic                d_ready,
  input  logic [2:0]          d_opcode,
  input  logic [1:0]          d_param,
  input  logic [SOURCE_W-1:0] d_source,
  input  logic [SINK_W-1:0]   d_sink,
  input  logic [255:0]        d_data,
  input  logic                e_valid,
  input  logic                e_ready,
  input  logic [SINK_W-1:0]   e_sink,
  output logic [7:0]          channel,
  output logic [7:0]          opcode,
  output logic [7:0]          param,
  output logic [7:0]          source,
  output logic [7:0]          sink,
  output logic [63:0]         address,
  output logic [63:0]         data_0,
  output logic [63:0]         data_1,
  output logic [63:0]         data_2,
  output logic [63:0]         data_3,
  output logic [63:0]         stamp,
  output logic                wen,
  output logic                overflow,
  output logic [15:0]         drop_cnt
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = 406;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  // stored record: {stamp[405:342], data[341:86], address[85:22], sink[21:14], source[13:6], param[5:3], opcode[2:0]}
  logic [RW-1:0]        mem_q [5][FIFO_DEPTH];
  logic [RW-1:0]        mem_d [5][FIFO_DEPTH];
  logic [RW-1:0]        in_rec [5];
  logic [4:0][CW-1:0]   cnt_q, cnt_d;
  logic [4:0][PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [4:0]           fire, acc, deq;
  logic [2:0]           ptr_q, ptr_d, chan_q, chan_d, gnt, ndrop;
  logic                 gv, wen_q, wen_d, ovf_q, ovf_d;
  logic [63:0]          stamp_q, stamp_d;
  logic [RW-1:0]        orec_q, orec_d;
  logic [15:0]          drop_q, drop_d;
  logic [16:0]          drop_sum;

  function automatic logic [2:0] rr(input logic [2:0] p, input int k);
    int s;
    s = int'(p) + k;
    return 3'(s >= 5 ? s - 5 : s);
  endfunction

  always_comb begin
    fire = {e_valid & e_ready, d_valid & d_ready, c_valid & c_ready, b_valid & b_ready, a_valid & a_ready} & {5{log_en}};
    in_rec[0] = {stamp_q, a_data, 64'(a_address), 8'd0, 8'(a_source), a_param, a_opcode};
    in_rec[1] = {stamp_q, 256'd0, 64'(b_address), 8'd0, 8'(b_source), 1'b0, b_param, b_opcode};
    in_rec[2] = {stamp_q, c_data, 64'(c_address), 8'd0, 8'(c_source), c_param, c_opcode};
    in_rec[3] = {stamp_q, d_data, 64'd0, 8'(d_sink), 8'(d_source), 1'b0, d_param, d_opcode};
    in_rec[4] = {stamp_q, 256'd0, 64'd0, 8'(e_sink), 8'd0, 6'd0};
  end

  // scan from lowest to highest priority so the last hit is the winner
  always_comb begin
    gv = 1'b0;
    gnt = ptr_q;
    for (int k = 4; k >= 0; k--) begin
      if (cnt_q[rr(ptr_q, k)] != '0) begin
        gv = 1'b1;
        gnt = rr(ptr_q, k);
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    deq = '0;
    acc = '0;
    ndrop = '0;
    cnt_d = cnt_q;
    wr_d = wr_q;
    rd_d = rd_q;
    for (int i = 0; i < 5; i++) begin
      deq[i] = gv && gnt == 3'(i);
      acc[i] = fire[i] && (cnt_q[i] != FULL || deq[i]);
      ndrop = ndrop + 3'(fire[i] && !acc[i]);
      cnt_d[i] = cnt_q[i] + CW'(acc[i]) - CW'(deq[i]);
      wr_d[i] = wr_q[i] + PW'(acc[i]);
      rd_d[i] = rd_q[i] + PW'(deq[i]);
      if (acc[i]) mem_d[i][wr_q[i]] = in_rec[i];
    end
    drop_sum = 17'(drop_q) + 17'(ndrop);
    drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    ovf_d = ovf_q || ndrop != '0;
    ptr_d = gv ? (gnt == 3'd4 ? 3'd0 : gnt + 3'd1) : ptr_q;
    wen_d = gv;
    chan_d = gv ? gnt : chan_q;
    orec_d = gv ? mem_q[gnt][rd_q[gnt]] : orec_q;
    stamp_d = stamp_q + 64'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      ptr_q <= '0;
      chan_q <= '0;
      orec_q <= '0;
      wen_q <= 1'b0;
      ovf_q <= 1'b0;
      drop_q <= '0;
      stamp_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      ptr_q <= ptr_d;
      chan_q <= chan_d;
      orec_q <= orec_d;
      wen_q <= wen_d;
      ovf_q <= ovf_d;
      drop_q <= drop_d;
      stamp_q <= stamp_d;
    end
  end

  always_ff @(posedge clock) mem_q <= mem_d;

  assign channel  = {5'd0, chan_q};
  assign opcode   = {5'd0, orec_q[2:0]};
  assign param    = {5'd0, orec_q[5:3]};
  assign source   = orec_q[13:6];
  assign sink     = orec_q[21:14];
  assign address  = orec_q[85:22];
  assign data_0   = orec_q[149:86];
  assign data_1   = orec_q[213:150];
  assign data_2   = orec_q[277:214];
  assign data_3   = orec_q[341:278];
  assign stamp    = orec_q[405:342];
  assign wen      = wen_q;
  assign overflow = ovf_q;
  assign drop_cnt = drop_q;
endmodule

// File: tb/tb_tl_log_collector.sv
// tb_tl_log_collector: randomized and directed bench for tl_log_collector against a queue-based reference model
module tb_tl_log_collector;
  localparam int DEPTH = 2;
  localparam int AW = 48;
  localparam int SW = 10;
  localparam int KW = 6;
  logic clock = 1'b0, reset = 1'b1, log_en = 1'b0;
  logic a_valid, a_ready, b_valid, b_ready, c_valid, c_ready, d_valid, d_ready, e_valid, e_ready;
  logic [2:0] a_opcode, a_param, b_opcode, c_opcode, c_param, d_opcode;
  logic [1:0] b_param, d_param;
  logic [SW-1:0] a_source, b_source, c_source, d_source;
  logic [AW-1:0] a_address, b_address, c_address;
  logic [KW-1:0] d_sink, e_sink;
  logic [255:0] a_data, c_data, d_data;
  logic [7:0] channel, opcode, param, source, sink;
  logic [63:0] address, data_0, data_1, data_2, data_3, stamp;
  logic wen, overflow;
  logic [15:0] drop_cnt;
  int ncomp = 0, nfail = 0;

  always #5 clock = ~clock;

  tl_log_collector #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW), .SOURCE_W(SW), .SINK_W(KW)) dut (
    .clock(clock), .reset(reset), .log_en(log_en),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_source(a_source), .a_address(a_address), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_opcode(b_opcode), .b_param(b_param),
    .b_source(b_source), .b_address(b_address),
    .c_valid(c_valid), .c_ready(c_ready), .c_opcode(c_opcode), .c_param(c_param),
    .c_source(c_source), .c_address(c_address), .c_data(c_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_source(d_source), .d_sink(d_sink), .d_data(d_data),
    .e_valid(e_valid), .e_ready(e_ready), .e_sink(e_sink),
    .channel(channel), .opcode(opcode), .param(param), .source(source), .sink(sink),
    .address(address), .data_0(data_0), .data_1(data_1), .data_2(data_2), .data_3(data_3),
    .stamp(stamp), .wen(wen), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  typedef struct {
    int ch;
    logic [7:0] op, par, src, snk;
    logic [63:0] addr;
    logic [255:0] data;
    logic [63:0] st;
  } rec_t;

  rec_t pend[$];
  rec_t e_rec;
  logic e_wen = 1'b0, e_ovf = 1'b0;
  int e_drop = 0, ptr = 0, g, drops;
  int n[5];
  longint unsigned m_stamp = 0;
  bit started = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncomp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit fires(int c);
    case (c)
      0: return log_en && a_valid && a_ready;
      1: return log_en && b_valid && b_ready;
      2: return log_en && c_valid && c_ready;
      3: return log_en && d_valid && d_ready;
      default: return log_en && e_valid && e_ready;
    endcase
  endfunction

  function automatic rec_t beat(int c, logic [63:0] st);
    rec_t r;
    r = '{default: '0};
    r.ch = c;
    r.st = st;
    case (c)
      0: begin r.op = {5'b0, a_opcode}; r.par = {5'b0, a_param}; r.src = a_source[7:0]; r.addr = {16'b0, a_address}; r.data = a_data; end
      1: begin r.op = {5'b0, b_opcode}; r.par = {6'b0, b_param}; r.src = b_source[7:0]; r.addr = {16'b0, b_address}; end
      2: begin r.op = {5'b0, c_opcode}; r.par = {5'b0, c_param}; r.src = c_source[7:0]; r.addr = {16'b0, c_address}; r.data = c_data; end
      3: begin r.op = {5'b0, d_opcode}; r.par = {6'b0, d_param}; r.src = d_source[7:0]; r.snk = {2'b0, d_sink}; r.data = d_data; end
      default: r.snk = {2'b0, e_sink};
    endcase
    return r;
  endfunction

  // reference model: one flat queue of pending beats, tagged by channel
  always @(posedge clock) begin
    if (reset) begin
      pend.delete();
      ptr = 0;
      m_stamp = 0;
      e_wen = 1'b0;
      e_rec = '{default: '0};
      e_ovf = 1'b0;
      e_drop = 0;
      started = 1'b1;
    end else begin
      foreach (n[c]) n[c] = 0;
      foreach (pend[i]) n[pend[i].ch]++;
      g = -1;
      for (int k = 0; k < 5; k++) if (g < 0 && n[(ptr + k) % 5] > 0) g = (ptr + k) % 5;
      e_wen = g >= 0;
      if (g >= 0) begin
        for (int i = 0; i < pend.size(); i++) begin
          if (pend[i].ch == g) begin
            e_rec = pend[i];
            pend.delete(i);
            break;
          end
        end
        ptr = (g + 1) % 5;
      end
      drops = 0;
      for (int c = 0; c < 5; c++) begin
        if (fires(c)) begin
          if (n[c] < DEPTH || g == c) pend.push_back(beat(c, 64'(m_stamp)));
          else drops++;
        end
      end
      e_drop = (e_drop + drops > 65535) ? 65535 : e_drop + drops;
      e_ovf = e_ovf || drops > 0;
      m_stamp++;
    end
  end

  always @(negedge clock) begin
    if (started) begin
      chk("wen", 64'(wen), 64'(e_wen));
      chk("channel", 64'(channel), 64'(e_rec.ch));
      chk("opcode", 64'(opcode), 64'(e_rec.op));
      chk("param", 64'(param), 64'(e_rec.par));
      chk("source", 64'(source), 64'(e_rec.src));
      chk("sink", 64'(sink), 64'(e_rec.snk));
      chk("address", address, e_rec.addr);
      chk("data_0", data_0, e_rec.data[63:0]);
      chk("data_1", data_1, e_rec.data[127:64]);
      chk("data_2", data_2, e_rec.data[191:128]);
      chk("data_3", data_3, e_rec.data[255:192]);
      chk("stamp", stamp, e_rec.st);
      chk("overflow", 64'(overflow), 64'(e_ovf));
      chk("drop_cnt", 64'(drop_cnt), 64'(e_drop));
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    {a_valid, a_ready, b_valid, b_ready, c_valid, c_ready, d_valid, d_ready, e_valid, e_ready} = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  function automatic logic [255:0] rnd256();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic randomize_fields();
    a_opcode = 3'($urandom); a_param = 3'($urandom); a_source = SW'($urandom); a_address = AW'({$urandom(), $urandom()}); a_data = rnd256();
    b_opcode = 3'($urandom); b_param = 2'($urandom); b_source = SW'($urandom); b_address = AW'({$urandom(), $urandom()});
    c_opcode = 3'($urandom); c_param = 3'($urandom); c_source = SW'($urandom); c_address = AW'({$urandom(), $urandom()}); c_data = rnd256();
    d_opcode = 3'($urandom); d_param = 2'($urandom); d_source = SW'($urandom); d_sink = KW'($urandom); d_data = rnd256();
    e_sink = KW'($urandom);
  endtask

  initial begin
    int cnt;
    idle();
    randomize_fields();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    chk("rst_wen", 64'(wen), 64'd0);
    chk("rst_stamp", stamp, 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    log_en = 1'b1;
    repeat (10) cyc();
    a_valid = 1'b1; a_ready = 1'b1; a_opcode = 3'd4; a_param = 3'd0; a_source = 10'h12;
    a_address = 48'h0000_8000_0040; a_data = {32{8'h55}};
    cyc();
    idle();
    cyc();
    chk("t1_wen", 64'(wen), 64'd1);
    chk("t1_channel", 64'(channel), 64'd0);
    chk("t1_opcode", 64'(opcode), 64'd4);
    chk("t1_source", 64'(source), 64'h12);
    chk("t1_sink", 64'(sink), 64'd0);
    chk("t1_address", address, 64'h0000_0000_8000_0040);
    chk("t1_data_3", data_3, 64'h5555_5555_5555_5555);
    chk("t1_stamp", stamp, 64'd10);
    cyc();
    chk("t1_wen_one_cycle", 64'(wen), 64'd0);
    do_reset();
    repeat (20) cyc();
    a_valid = 1'b1; a_ready = 1'b1;
    d_valid = 1'b1; d_ready = 1'b1; d_source = 10'h3A5; d_sink = 6'h2F;
    e_valid = 1'b1; e_ready = 1'b1; e_sink = 6'h11;
    cyc();
    idle();
    cyc();
    chk("t2_wen0", 64'(wen), 64'd1);
    chk("t2_ch0", 64'(channel), 64'd0);
    chk("t2_stamp0", stamp, 64'd20);
    cyc();
    chk("t2_wen1", 64'(wen), 64'd1);
    chk("t2_ch1", 64'(channel), 64'd3);
    chk("t2_stamp1", stamp, 64'd20);
    chk("trunc_source", 64'(source), 64'hA5);
    chk("trunc_sink", 64'(sink), 64'h2F);
    chk("trunc_address", address, 64'd0);
    cyc();
    chk("t2_wen2", 64'(wen), 64'd1);
    chk("t2_ch2", 64'(channel), 64'd4);
    chk("t2_stamp2", stamp, 64'd20);
    chk("t2_esink", 64'(sink), 64'h11);
    do_reset();
    {a_valid, a_ready, b_valid, b_ready, c_valid, c_ready, d_valid, d_ready, e_valid, e_ready} = '1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (i == 2) begin
        idle();
        chk("ovf_drop_cnt", 64'(drop_cnt), 64'd3);
        chk("ovf_overflow", 64'(overflow), 64'd1);
      end
      cnt += int'(wen);
    end
    chk("ovf_records", 64'(cnt), 64'd12);
    log_en = 1'b0;
    c_valid = 1'b1; c_ready = 1'b1;
    cyc();
    idle();
    cnt = 0;
    repeat (4) begin
      cyc();
      cnt += int'(wen);
    end
    chk("log_en_block", 64'(cnt), 64'd0);
    log_en = 1'b1;
    b_valid = 1'b1; b_ready = 1'b1; b_param = 2'd2;
    cyc();
    log_en = 1'b0;
    idle();
    cyc();
    chk("drain_wen", 64'(wen), 64'd1);
    chk("drain_channel", 64'(channel), 64'd1);
    chk("drain_param", 64'(param), 64'd2);
    log_en = 1'b1;
    {a_valid, a_ready, b_valid, b_ready, c_valid, c_ready} = '1;
    cyc();
    idle();
    do_reset();
    chk("mid_rst_wen", 64'(wen), 64'd0);
    chk("mid_rst_overflow", 64'(overflow), 64'd0);
    chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
    a_valid = 1'b1; a_ready = 1'b1;
    cyc();
    idle();
    chk("mid_rst_quiet", 64'(wen), 64'd0);
    cyc();
    chk("mid_rst_new_wen", 64'(wen), 64'd1);
    chk("mid_rst_new_stamp", stamp, 64'd0);
    cnt = 0;
    repeat (6) begin
      cyc();
      cnt += int'(wen);
    end
    chk("mid_rst_no_stale", 64'(cnt), 64'd0);
    for (int i = 0; i < 600; i++) begin
      randomize_fields();
      {a_valid, a_ready, b_valid, b_ready, c_valid, c_ready, d_valid, d_ready, e_valid, e_ready} = 10'($urandom);
      if ($urandom_range(0, 3) != 0) {a_ready, b_ready, c_ready, d_ready, e_ready} = '1;
      log_en = $urandom_range(0, 9) != 0;
      reset = $urandom_range(0, 99) == 0;
      cyc();
    end
    reset = 1'b0;
    idle();
    repeat (30) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule
